// File: rtl/proc_core_mc.sv
// ============================================================================
//  Module   : proc_core_mc
//  Brief    : Multi-cycle core (FETCH/EXEC/HALT), 4x DATA_W register file,
//             ALU with zero flag, req/ack instruction fetch, retire/debug port.
//             Optional macro PROC_RET_CNT_EN enables the 32-bit retire counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_core_mc #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic              halted,
    output logic              zero_flag,
    output logic [DATA_W-1:0] dbg_ra,
    output logic              retire,
    output logic [31:0]       ret_cnt
);

    localparam logic [2:0] c_OP_LDI  = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_SUB  = 3'b011;
    localparam logic [2:0] c_OP_AND  = 3'b100;
    localparam logic [2:0] c_OP_XOR  = 3'b101;
    localparam logic [2:0] c_OP_JZ   = 3'b110;
    localparam logic [2:0] c_OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PC_W-1:0]     r_pc;
    logic [15:0]         r_ir;
    logic [DATA_W-1:0]   r_regs [4];
    logic                r_zero;

    logic [2:0]          w_op;
    logic [1:0]          w_rd;
    logic [1:0]          w_rs;
    logic [8:0]          w_imm9;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_result;
    logic                w_wr;
    logic                w_taken;

    assign w_op   = r_ir[15:13];
    assign w_rd   = r_ir[12:11];
    assign w_rs   = r_ir[10:9];
    assign w_imm9 = r_ir[8:0];
    assign w_a    = r_regs[w_rd];
    assign w_b    = r_regs[w_rs];

    // JZ reads the flag as it stood before this instruction; JZ never writes it.
    assign w_taken = (w_op == c_OP_JZ) && r_zero;

    always_comb begin
        w_result = '0;
        w_wr     = 1'b0;
        case (w_op)
            c_OP_LDI: begin w_result = DATA_W'($signed(w_imm9)); w_wr = 1'b1; end
            c_OP_ADD: begin w_result = w_a + w_b;                w_wr = 1'b1; end
            c_OP_SUB: begin w_result = w_a - w_b;                w_wr = 1'b1; end
            c_OP_AND: begin w_result = w_a & w_b;                w_wr = 1'b1; end
            c_OP_XOR: begin w_result = w_a ^ w_b;                w_wr = 1'b1; end
            default:  begin w_result = '0;                       w_wr = 1'b0; end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: if (imem_ack) w_next = S_EXEC;
            S_EXEC:  w_next = (w_op == c_OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_zero  <= 1'b0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && imem_ack) begin
                r_ir <= imem_data;
                r_pc <= r_pc + PC_W'(1);
            end
            if (r_state == S_EXEC) begin
                if (w_wr) begin
                    r_regs[w_rd] <= w_result;
                    r_zero       <= (w_result == '0);
                end
                if (w_taken) r_pc <= w_imm9[PC_W-1:0];
            end
        end
    end

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign halted    = (r_state == S_HALT);
    assign retire    = (r_state == S_EXEC);
    assign zero_flag = r_zero;
    assign dbg_ra    = r_regs[0];

`ifdef PROC_RET_CNT_EN
    logic [31:0] r_ret_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ret_cnt <= 32'd0;
        else if (retire) r_ret_cnt <= r_ret_cnt + 32'd1;
    end

    assign ret_cnt = r_ret_cnt;
`else
    assign ret_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_proc_core_mc.sv
// ============================================================================
//  Module   : tb_proc_core_mc
//  Brief    : Directed self-checking bench for proc_core_mc with a req/ack
//             imem model supporting programmable wait states.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_core_mc;

`ifdef PROC_RET_CNT_EN
    localparam bit c_RC_EN = 1'b1;
`else
    localparam bit c_RC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        halted;
    logic        zero_flag;
    logic [15:0] dbg_ra;
    logic        retire;
    logic [31:0] ret_cnt;

    logic [15:0] mem [256];
    logic [7:0]  fetch_log [64];
    int          n_fetch;
    int          n_ret;
    int          stab_err;
    int          wait_cycles = 0;
    int          wcnt;
    logic [7:0]  held_addr;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc;

    proc_core_mc #(.DATA_W(16), .PC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .halted    (halted),
        .zero_flag (zero_flag),
        .dbg_ra    (dbg_ra),
        .retire    (retire),
        .ret_cnt   (ret_cnt)
    );

    always #5 clk = ~clk;

    // Imem model, fetch logger and retire counter, all updated on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            imem_ack = 1'b0;
            wcnt     = 0;
            n_fetch  = 0;
            n_ret    = 0;
            stab_err = 0;
        end else begin
            if (retire) n_ret = n_ret + 1;
            if (imem_req) begin
                if (wcnt > 0 && imem_addr != held_addr) stab_err = stab_err + 1;
                held_addr = imem_addr;
                if (wcnt == wait_cycles) begin
                    imem_ack  = 1'b1;
                    imem_data = mem[imem_addr];
                    if (n_fetch < 64) fetch_log[n_fetch] = imem_addr;
                    n_fetch = n_fetch + 1;
                    wcnt    = 0;
                end else begin
                    imem_ack = 1'b0;
                    wcnt     = wcnt + 1;
                end
            end else begin
                if (wcnt > 0) stab_err = stab_err + 1;
                imem_ack = 1'b0;
                wcnt     = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_to_halt(input int max_cyc);
        cyc = 0;
        while (!halted && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
        end
        if (!halted) check("halt_timeout", 32'(cyc), 32'(max_cyc + 1));
    endtask

    initial begin
        // Check 1: LDI r0,5; LDI r1,3; ADD r0,r1; HALT with zero-wait imem
        clear_mem();
        mem[0] = 16'h2005; mem[1] = 16'h2803; mem[2] = 16'h4200; mem[3] = 16'hE000;
        wait_cycles = 0;
        do_reset();
        check("rst_req",    32'(imem_req),  32'd1);
        check("rst_addr",   32'(imem_addr), 32'd0);
        check("rst_halted", 32'(halted),    32'd0);
        check("rst_retire", 32'(retire),    32'd0);
        check("rst_zero",   32'(zero_flag), 32'd0);
        check("rst_ra",     32'(dbg_ra),    32'd0);
        check("rst_retcnt", ret_cnt,        32'd0);
        run_to_halt(100);
        check("c1_cycles",  32'(cyc),       32'd8);
        check("c1_ra",      32'(dbg_ra),    32'd8);
        check("c1_zero",    32'(zero_flag), 32'd0);
        check("c1_retires", 32'(n_ret),     32'd4);
        check("c1_retcnt",  ret_cnt,        c_RC_EN ? 32'd4 : 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("c1_halt_req",  32'(imem_req), 32'd0);
        check("c1_halt_hold", 32'(halted),   32'd1);
        check("c1_halt_ret",  32'(n_ret),    32'd4);
        rst = 1'b1;
        #1;
        check("c1_rst_retcnt", ret_cnt, 32'd0);

        // Check 2: SUB to zero, then JZ 0x10 taken
        clear_mem();
        mem[0] = 16'h2007; mem[1] = 16'h2807; mem[2] = 16'h6200; mem[3] = 16'hC010;
        do_reset();
        run_to_halt(100);
        check("c2_zero",   32'(zero_flag),    32'd1);
        check("c2_ra",     32'(dbg_ra),       32'd0);
        check("c2_jz_dst", 32'(fetch_log[4]), 32'h10);

        // Check 3: JZ not taken, LDI sign extension observed through r0
        clear_mem();
        mem[0] = 16'h2001; mem[1] = 16'hC010; mem[2] = 16'h31FF;
        mem[3] = 16'hA000; mem[4] = 16'h4400; mem[5] = 16'hE000;
        do_reset();
        run_to_halt(100);
        check("c3_jz_fall", 32'(fetch_log[2]), 32'h02);
        check("c3_sext",    32'(dbg_ra),       32'hFFFF);
        check("c3_zero",    32'(zero_flag),    32'd0);

        // AND with distinct bit patterns
        clear_mem();
        mem[0] = 16'h20F6; mem[1] = 16'h383C; mem[2] = 16'h8600; mem[3] = 16'hE000;
        do_reset();
        run_to_halt(100);
        check("and_ra", 32'(dbg_ra), 32'h0034);

        // Check 4: three wait states per fetch on the Check 1 program
        clear_mem();
        mem[0] = 16'h2005; mem[1] = 16'h2803; mem[2] = 16'h4200; mem[3] = 16'hE000;
        wait_cycles = 3;
        do_reset();
        run_to_halt(200);
        check("c4_cycles", 32'(cyc),      32'd20);
        check("c4_ra",     32'(dbg_ra),   32'd8);
        check("c4_stable", 32'(stab_err), 32'd0);
        check("c4_retires",32'(n_ret),    32'd4);
        wait_cycles = 0;

        // Check 5: PC wrap 0xFF -> 0x00, then ADD 0xFFFF+1 wraps to zero
        clear_mem();
        mem[0]    = 16'hC020; mem[1]    = 16'h2000; mem[2]    = 16'hC0FF;
        mem[8'hFF] = 16'h0000;
        mem[8'h20] = 16'h21FF; mem[8'h21] = 16'h2801; mem[8'h22] = 16'h4200;
        mem[8'h23] = 16'hE000;
        do_reset();
        run_to_halt(100);
        check("c5_pre_wrap", 32'(fetch_log[3]), 32'hFF);
        check("c5_wrap",     32'(fetch_log[4]), 32'h00);
        check("c5_ra",       32'(dbg_ra),       32'd0);
        check("c5_zero",     32'(zero_flag),    32'd1);

        // Check 6: reset during EXEC of ADD
        clear_mem();
        mem[0] = 16'h2005; mem[1] = 16'h2803; mem[2] = 16'h4200; mem[3] = 16'hE000;
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        check("c6_in_exec", 32'(retire), 32'd1);
        check("c6_pre_ra",  32'(dbg_ra), 32'd5);
        rst = 1'b1;
        #1;
        check("c6_ra",     32'(dbg_ra),    32'd0);
        check("c6_req",    32'(imem_req),  32'd1);
        check("c6_addr",   32'(imem_addr), 32'd0);
        check("c6_retire", 32'(retire),    32'd0);
        check("c6_retcnt", ret_cnt,        32'd0);
        @(posedge clk);
        #1;
        check("c6_no_write", 32'(dbg_ra), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
